// File: rtl/md_defs.sv
// Shared HI/LO instruction-class encodings and multiply/divide unit latencies.
package md_defs;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_MF    = 3'd7
  } md_type_e;

  localparam int MD_MULT_LAT = 5;
  localparam int MD_DIV_LAT  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_issue_ctrl.sv
// E-stage issue controller for the HI/LO multiply/divide unit: decode, busy
// shadow counter, D-stage stall and sticky protocol-error flag.
module md_issue_ctrl
  import md_defs::*;
#(
  parameter int MULT_LAT = MD_MULT_LAT,
  parameter int DIV_LAT  = MD_DIV_LAT,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             e_valid,
  input  logic [2:0]       e_md_type,
  input  logic             d_md_use,
  input  logic             md_busy,
  output logic             md_start,
  output logic             md_op,
  output logic             md_sign,
  output logic             md_we,
  output logic             md_write_sel,
  output logic             stall_d,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             proto_err
);

  md_type_e         md_type;
  md_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             is_md, is_mt, idle, is_div, err_now;

  assign md_type = md_type_e'(e_md_type);
  assign idle    = (pend_cnt == '0);
  assign is_div  = (md_type == MD_DIV) || (md_type == MD_DIVU);

  // Decode: start and write enable are only granted while the unit is idle
  always_comb begin
    is_md        = e_valid && (md_type inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU});
    is_mt        = e_valid && (md_type inside {MD_MTHI, MD_MTLO});
    md_start     = is_md && idle;
    md_op        = md_start && is_div;
    md_sign      = md_start && ((md_type == MD_MULT) || (md_type == MD_DIV));
    md_we        = is_mt && idle;
    md_write_sel = md_we && (md_type == MD_MTLO);
    stall_d      = d_md_use && (md_start || !idle || md_busy);
  end

  // A HI/LO op reaching E while busy, or busy disagreeing with the shadow
  assign err_now = (md_busy != !idle) || ((is_md || is_mt) && !idle);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = pend_cnt;
    case (state)
      ST_IDLE: begin
        if (md_start) begin
          state_nxt = ST_RUN;
          cnt_nxt   = md_op ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end
      end
      ST_RUN: begin
        cnt_nxt = pend_cnt - 1'b1;
        if (pend_cnt == CNT_W'(1)) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      pend_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      pend_cnt <= cnt_nxt;
      if (err_now) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with a behavioural busy model of the unit.
module tb_md_issue_ctrl;
  import md_defs::*;

  logic       clk = 1'b0;
  logic       reset, e_valid, d_md_use, md_busy;
  logic [2:0] e_md_type;
  logic       md_start, md_op, md_sign, md_we, md_write_sel, stall_d, proto_err;
  logic [3:0] pend_cnt;

  int errors = 0;
  int checks = 0;

  // Unit model: busy registered on the start edge, held for the op latency
  int   ucnt = 0;
  logic force_idle = 1'b0;
  assign md_busy = (ucnt != 0) && !force_idle;

  always @(posedge clk) begin
    if (reset) ucnt <= 0;
    else if (md_start) ucnt <= md_op ? MD_DIV_LAT : MD_MULT_LAT;
    else if (ucnt > 0) ucnt <= ucnt - 1;
  end

  always #5 clk = ~clk;

  md_issue_ctrl dut (
    .clk(clk), .reset(reset), .e_valid(e_valid), .e_md_type(e_md_type),
    .d_md_use(d_md_use), .md_busy(md_busy), .md_start(md_start), .md_op(md_op),
    .md_sign(md_sign), .md_we(md_we), .md_write_sel(md_write_sel),
    .stall_d(stall_d), .pend_cnt(pend_cnt), .proto_err(proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] t, input logic du);
    @(negedge clk);
    e_valid   = v;
    e_md_type = t;
    d_md_use  = du;
    #1;
  endtask

  task automatic chk_ctrl(input string tag, input logic st, input logic op, input logic sg,
                          input logic we, input logic ws);
    chk({tag, "_start"}, md_start, st);
    chk({tag, "_op"}, md_op, op);
    chk({tag, "_sign"}, md_sign, sg);
    chk({tag, "_we"}, md_we, we);
    chk({tag, "_wsel"}, md_write_sel, ws);
  endtask

  initial begin
    reset = 1'b1; e_valid = 1'b0; e_md_type = MD_NONE; d_md_use = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state
    drive(1'b0, MD_NONE, 1'b1);
    chk("rst_pend", pend_cnt, 0);
    chk("rst_err", proto_err, 0);
    chk("rst_stall", stall_d, 0);
    chk_ctrl("rst", 0, 0, 0, 0, 0);
    reset = 1'b0;

    // MULT issue and counter countdown 5..0
    drive(1'b1, MD_MULT, 1'b0);
    chk_ctrl("mult", 1, 0, 1, 0, 0);
    chk("mult_pend0", pend_cnt, 0);
    for (int k = 5; k >= 0; k--) begin
      drive(1'b0, MD_NONE, 1'b0);
      chk($sformatf("mult_pend%0d", k), pend_cnt, k);
      chk($sformatf("mult_busy%0d", k), md_busy, (k != 0));
      chk("mult_nostart", md_start, 0);
    end
    chk("mult_err", proto_err, 0);

    // DIVU with dependent HI/LO instruction in D
    drive(1'b1, MD_DIVU, 1'b1);
    chk_ctrl("divu", 1, 1, 0, 0, 0);
    chk("divu_stall_start", stall_d, 1);
    for (int k = 10; k >= 1; k--) begin
      drive(1'b0, MD_NONE, 1'b1);
      chk($sformatf("divu_pend%0d", k), pend_cnt, k);
      chk("divu_stall", stall_d, 1);
      chk("divu_nostart", md_start, 0);
    end
    drive(1'b0, MD_NONE, 1'b1);
    chk("divu_pend_end", pend_cnt, 0);
    chk("divu_stall_end", stall_d, 0);
    chk("divu_err", proto_err, 0);

    // MTLO / MTHI right after completion, then MF idle
    drive(1'b1, MD_MTLO, 1'b0);
    chk_ctrl("mtlo", 0, 0, 0, 1, 1);
    drive(1'b1, MD_MTHI, 1'b0);
    chk("mtlo_pend", pend_cnt, 0);
    chk_ctrl("mthi", 0, 0, 0, 1, 0);
    drive(1'b1, MD_MF, 1'b0);
    chk_ctrl("mf", 0, 0, 0, 0, 0);

    // Bubble carrying a DIV type
    drive(1'b0, MD_DIV, 1'b1);
    chk_ctrl("bubble", 0, 0, 0, 0, 0);
    chk("bubble_stall", stall_d, 0);
    drive(1'b0, MD_DIV, 1'b1);
    chk("bubble_pend", pend_cnt, 0);

    // Unit busy dropped the cycle after a MULT start
    drive(1'b1, MD_MULT, 1'b0);
    chk("perr_start", md_start, 1);
    drive(1'b0, MD_NONE, 1'b0);
    force_idle = 1'b1;
    #1;
    chk("perr_pend", pend_cnt, 5);
    chk("perr_not_yet", proto_err, 0);
    drive(1'b0, MD_NONE, 1'b0);
    force_idle = 1'b0;
    chk("perr_set", proto_err, 1);
    repeat (5) drive(1'b0, MD_NONE, 1'b0);
    chk("perr_idle_pend", pend_cnt, 0);
    chk("perr_sticky", proto_err, 1);

    // Reset in the middle of a DIV at pend_cnt=7
    drive(1'b1, MD_DIV, 1'b0);
    chk_ctrl("div", 1, 1, 1, 0, 0);
    repeat (4) drive(1'b0, MD_NONE, 1'b0);
    chk("div_pend7", pend_cnt, 7);
    reset = 1'b1;
    drive(1'b0, MD_NONE, 1'b0);
    reset = 1'b0;
    chk("mrst_pend", pend_cnt, 0);
    chk("mrst_err", proto_err, 0);
    chk("mrst_busy", md_busy, 0);
    drive(1'b1, MD_MULT, 1'b0);
    chk_ctrl("mrst_mult", 1, 0, 1, 0, 0);
    drive(1'b0, MD_NONE, 1'b0);
    chk("mrst_mult_pend", pend_cnt, 5);

    // HI/LO instruction reaching E while busy: blocked and flagged
    drive(1'b1, MD_MTHI, 1'b0);
    chk_ctrl("illegal", 0, 0, 0, 0, 0);
    chk("illegal_err0", proto_err, 0);
    drive(1'b0, MD_NONE, 1'b0);
    chk("illegal_err1", proto_err, 1);
    chk("illegal_pend", pend_cnt, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
